// File: rtl/decode_issue_pkg.sv
// Shared decode definitions: instruction field layout, opcode set, instruction
// classes and the register-usage profile of each class.
package decode_issue_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned RD_LSB  = 24;
  localparam int unsigned RS_LSB  = 20;
  localparam int unsigned RX_LSB  = 16;
  localparam int unsigned RK_LSB  = 12;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned PC_IDX  = 15;

  typedef enum logic [3:0] {
    OP_ALU0   = 4'd0,  OP_ALU1  = 4'd1,  OP_ALU2  = 4'd2,  OP_ALU3 = 4'd3,
    OP_ALU4   = 4'd4,  OP_ALU5  = 4'd5,  OP_ALU6  = 4'd6,  OP_ALU7 = 4'd7,
    OP_LOAD   = 4'd8,  OP_STORE = 4'd9,  OP_BRANCH = 4'd10, OP_KREAD = 4'd11,
    OP_RSV12  = 4'd12, OP_RSV13 = 4'd13, OP_RSV14 = 4'd14, OP_NOP  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_KREAD, CLS_NOP, CLS_ILLEGAL
  } class_e;

  // rd marks RD used as a source (STORE); wr marks RD as a destination.
  typedef struct packed {
    logic rs;
    logic rx;
    logic rd;
    logic rk;
    logic wr;
  } use_t;

  function automatic class_e op_class(input opcode_e code);
    case (code)
      OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3,
      OP_ALU4, OP_ALU5, OP_ALU6, OP_ALU7: op_class = CLS_ALU;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_KREAD:  op_class = CLS_KREAD;
      OP_NOP:    op_class = CLS_NOP;
      default:   op_class = CLS_ILLEGAL;
    endcase
  endfunction

  function automatic use_t class_use(input class_e cls);
    use_t u;
    u = '0;
    case (cls)
      CLS_ALU:    begin u.rs = 1'b1; u.rx = 1'b1; u.wr = 1'b1; end
      CLS_LOAD:   begin u.rs = 1'b1; u.wr = 1'b1; end
      CLS_STORE:  begin u.rs = 1'b1; u.rd = 1'b1; end
      CLS_BRANCH: begin u.rs = 1'b1; u.rx = 1'b1; end
      CLS_KREAD:  begin u.rk = 1'b1; u.wr = 1'b1; end
      default:    u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writer and
// cleared at writeback; flags a hazard for the instruction currently offered.
module decode_scoreboard
  import decode_issue_pkg::*;
#(
  parameter int DIR = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DIR-1:0] rd,
  input  logic [DIR-1:0] rs,
  input  logic [DIR-1:0] rx,
  input  logic [DIR-1:0] rk,
  input  use_t           uses,
  input  logic           set,
  input  logic           wb_valid,
  input  logic [DIR-1:0] wb_rd,
  output logic           hazard
);

  localparam int unsigned NREG = 1 << DIR;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] release_mask;
  logic [NREG-1:0] live;
  logic [NREG-1:0] pending_next;

  always_comb begin
    release_mask = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      release_mask[i] = wb_valid && (wb_rd == DIR'(i));
    end
  end

  // A register retiring this cycle no longer blocks a reader.
  assign live = pending & ~release_mask;

  assign hazard = (uses.rs && live[rs]) || (uses.rx && live[rx]) ||
                  (uses.rd && live[rd]) || (uses.rk && live[rk]) ||
                  (uses.wr && live[rd]);

  always_comb begin
    pending_next = live;
    if (set) pending_next[rd] = 1'b1;
    pending_next[PC_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes the offered instruction, stalls on register
// hazards and presents the decoded fields through a one-entry output register.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int BUS = 32,
  parameter int DIR = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BUS-1:0] in_instr,
  input  logic [BUS-1:0] in_pc,
  input  logic           flush,
  input  logic           wb_valid,
  input  logic [DIR-1:0] wb_rd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DIR-1:0] RD,
  output logic [DIR-1:0] RS,
  output logic [DIR-1:0] RX,
  output logic [DIR-1:0] RK,
  output logic           WE,
  output logic [3:0]     op,
  output logic [BUS-1:0] imm,
  output logic [BUS-1:0] pc,
  output logic           illegal
);

  opcode_e        dec_op;
  class_e         dec_cls;
  use_t           dec_use;
  use_t           chk_use;
  logic [DIR-1:0] dec_rd, dec_rs, dec_rx, dec_rk;
  logic [BUS-1:0] dec_imm;
  logic           dec_illegal;
  logic           dec_we;
  logic           hazard;
  logic           accept;

  always_comb begin
    dec_op  = opcode_e'(in_instr[OP_LSB +: OP_W]);
    dec_rd  = in_instr[RD_LSB +: DIR];
    dec_rs  = in_instr[RS_LSB +: DIR];
    dec_rx  = in_instr[RX_LSB +: DIR];
    dec_rk  = in_instr[RK_LSB +: DIR];
    dec_imm = {{(BUS-IMM_W){in_instr[IMM_LSB+IMM_W-1]}}, in_instr[IMM_LSB +: IMM_W]};
    dec_cls = op_class(dec_op);
    dec_use = class_use(dec_cls);
    // Writing the PC through RD is illegal and demoted to a no-write.
    dec_illegal = (dec_cls == CLS_ILLEGAL) || (dec_use.wr && (dec_rd == DIR'(PC_IDX)));
    dec_we      = dec_use.wr && !dec_illegal;
    chk_use     = dec_use;
    chk_use.wr  = dec_we;
  end

  decode_scoreboard #(.DIR(DIR)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd       (dec_rd),
    .rs       (dec_rs),
    .rx       (dec_rx),
    .rk       (dec_rk),
    .uses     (chk_use),
    .set      (accept && dec_we),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .hazard   (hazard)
  );

  assign in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      RD        <= '0;
      RS        <= '0;
      RX        <= '0;
      RK        <= '0;
      WE        <= 1'b0;
      op        <= '0;
      imm       <= '0;
      pc        <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      RD        <= dec_rd;
      RS        <= dec_rs;
      RX        <= dec_rx;
      RK        <= dec_rk;
      WE        <= dec_we;
      op        <= dec_op;
      imm       <= dec_imm;
      pc        <= in_pc;
      illegal   <= dec_illegal;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: the driver pushes expected decodes into a
// queue on acceptance; a monitor pops and compares at every output handshake.
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  RD, RS, RX, RK;
  logic        WE;
  logic [3:0]  op;
  logic [31:0] imm;
  logic [31:0] pc;
  logic        illegal;

  decode_issue #(.BUS(32), .DIR(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .out_valid(out_valid), .out_ready(out_ready),
    .RD(RD), .RS(RS), .RX(RX), .RK(RK), .WE(WE), .op(op), .imm(imm),
    .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd, rs, rx, rk;
    logic        we;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] mk_i(input logic [3:0] o, input logic [3:0] d,
                                       input logic [3:0] s, input logic [3:0] x,
                                       input logic [15:0] i16);
    return {o, d, s, x, i16};
  endfunction

  function automatic exp_t mk_e(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s,
                                input logic [3:0] x, input logic [3:0] k, input logic [31:0] i32,
                                input logic w, input logic il, input logic [31:0] p);
    exp_t e;
    e.op = o; e.rd = d; e.rs = s; e.rx = x; e.rk = k;
    e.we = w; e.imm = i32; e.pc = p; e.ill = il;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got op=%0h pc=%0h want no output", op, pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_item", {op, RD, RS, RX, RK, WE, imm, pc, illegal}, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string nm, input logic [31:0] instr, input logic [31:0] p,
                       input logic acc, input exp_t e);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = p;
    @(negedge clk);
    check(nm, in_ready, acc);
    if (acc) sb.push_back(e);
    step();
    in_valid = 1'b0;
  endtask

  // BRANCH reading idx in both RS and RX: in_ready reports the pending bit.
  task automatic probe(input string nm, input logic [3:0] idx, input logic ready_exp);
    in_valid = 1'b0;
    in_instr = mk_i(4'hA, 4'h0, idx, idx, 16'h0000);
    @(negedge clk);
    check(nm, in_ready, ready_exp);
    step();
  endtask

  task automatic retire(input logic [3:0] idx);
    wb_valid = 1'b1;
    wb_rd    = idx;
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outputs", {out_valid, op, RD, RS, RX, RK, WE, imm, pc, illegal}, '0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // ALU writer, then a dependent reader stalled until writeback of r3
    issue("alu_r3", mk_i(4'h1, 4'h3, 4'h1, 4'h2, 16'h0000), 32'h100, 1'b1,
          mk_e(4'h1, 4'h3, 4'h1, 4'h2, 4'h0, 32'h0, 1'b1, 1'b0, 32'h100));
    issue("raw_stall", mk_i(4'h2, 4'h4, 4'h3, 4'h0, 16'h0000), 32'h104, 1'b0, '0);
    wb_valid = 1'b1; wb_rd = 4'd3;
    issue("raw_wb_bypass", mk_i(4'h2, 4'h4, 4'h3, 4'h0, 16'h0000), 32'h104, 1'b1,
          mk_e(4'h2, 4'h4, 4'h3, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h104));
    wb_valid = 1'b0;
    probe("pend3_cleared", 4'd3, 1'b1);
    probe("pend4_set", 4'd4, 1'b0);
    retire(4'd4);
    probe("pend4_retired", 4'd4, 1'b1);

    // same-cycle set and clear of r3: set wins
    issue("alu_r3_again", mk_i(4'h0, 4'h3, 4'h0, 4'h0, 16'h0000), 32'h108, 1'b1,
          mk_e(4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h108));
    wb_valid = 1'b1; wb_rd = 4'd3;
    issue("set_wins_issue", mk_i(4'h7, 4'h3, 4'h3, 4'h3, 16'h0000), 32'h10C, 1'b1,
          mk_e(4'h7, 4'h3, 4'h3, 4'h3, 4'h0, 32'h0, 1'b1, 1'b0, 32'h10C));
    wb_valid = 1'b0;
    probe("set_wins", 4'd3, 1'b0);
    retire(4'd3);
    probe("pend3_final", 4'd3, 1'b1);
    retire(4'd7);
    probe("wb_nonpending", 4'd7, 1'b1);

    // backpressure: output held for three cycles, no extra acceptance
    out_ready = 1'b0;
    issue("stall_a", mk_i(4'h5, 4'h6, 4'h7, 4'h8, 16'h1234), 32'h200, 1'b1,
          mk_e(4'h5, 4'h6, 4'h7, 4'h8, 4'h1, 32'h0000_1234, 1'b1, 1'b0, 32'h200));
    in_valid = 1'b1;
    in_instr = mk_i(4'h3, 4'h9, 4'hA, 4'hB, 16'h00F0);
    in_pc    = 32'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold", {out_valid, op, RD, RS, RX, RK, WE, imm, pc},
            {1'b1, 4'h5, 4'h6, 4'h7, 4'h8, 4'h1, 1'b1, 32'h0000_1234, 32'h200});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release", in_ready, 1'b1);
    sb.push_back(mk_e(4'h3, 4'h9, 4'hA, 4'hB, 4'h0, 32'h0000_00F0, 1'b1, 1'b0, 32'h204));
    step();
    in_valid = 1'b0;

    // illegal forms
    issue("load_rd15", mk_i(4'h8, 4'hF, 4'h1, 4'h0, 16'h0000), 32'h300, 1'b1,
          mk_e(4'h8, 4'hF, 4'h1, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h300));
    @(negedge clk);
    check("load_rd15_flags", {illegal, WE}, 2'b10);
    step();
    probe("pc_never_pending", 4'd15, 1'b1);
    probe("pend6_kept", 4'd6, 1'b0);
    issue("op13", mk_i(4'hD, 4'h2, 4'h0, 4'h0, 16'h0000), 32'h304, 1'b1,
          mk_e(4'hD, 4'h2, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h304));
    @(negedge clk);
    check("op13_flags", {illegal, WE}, 2'b10);
    step();

    // KREAD hazard on RK
    issue("kread_stall", mk_i(4'hB, 4'hC, 4'h0, 4'h0, 16'h6000), 32'h308, 1'b0, '0);
    wb_valid = 1'b1; wb_rd = 4'd6;
    issue("kread_go", mk_i(4'hB, 4'hC, 4'h0, 4'h0, 16'h6000), 32'h308, 1'b1,
          mk_e(4'hB, 4'hC, 4'h0, 4'h0, 4'h6, 32'h0000_6000, 1'b1, 1'b0, 32'h308));
    wb_valid = 1'b0;
    retire(4'd9);
    retire(4'd12);

    // sign extension and flush
    out_ready = 1'b0;
    issue("load_neg_imm", mk_i(4'h8, 4'h1, 4'h0, 4'h0, 16'h8001), 32'h400, 1'b1,
          mk_e(4'h8, 4'h1, 4'h0, 4'h0, 4'h8, 32'hFFFF_8001, 1'b1, 1'b0, 32'h400));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = mk_i(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    @(negedge clk);
    check("imm_sext", imm, 32'hFFFF_8001);
    check("flush_blocks", in_ready, 1'b0);
    void'(sb.pop_back());
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_drop", out_valid, 1'b0);
    step();
    probe("flush_keeps_pend", 4'd1, 1'b0);
    retire(4'd1);
    probe("pend1_retired", 4'd1, 1'b1);

    // reset during a stall with r5 pending
    out_ready = 1'b0;
    issue("alu_r5", mk_i(4'h0, 4'h5, 4'h0, 4'h0, 16'h0000), 32'h500, 1'b1,
          mk_e(4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h500));
    in_valid = 1'b1;
    in_instr = mk_i(4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
    @(negedge clk);
    check("r5_stall", in_ready, 1'b0);
    step();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_in_ready_low", in_ready, 1'b0);
    step();
    @(negedge clk);
    check("rst_mid_outputs", {out_valid, op, RD, RS, RX, RK, WE, imm, pc, illegal}, '0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    probe("rst_pend5_clear", 4'd5, 1'b1);

    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 Parameters SHALL be: BUS, default 32, instruction/data width; DIR, default 4, register index width (2**DIR registers, index 15 = PC).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 in_valid  in  1  fetch offers instruction.
REQ-005 in_ready  out  1  decode accepts instruction this cycle.
REQ-006 in_instr  in  BUS  instruction word.
REQ-007 in_pc  in  BUS  address of in_instr.
REQ-008 flush  in  1  discard held and offered instruction.
REQ-009 wb_valid  in  1  register-bank write retiring this cycle.
REQ-010 wb_rd  in  DIR  destination being retired.
REQ-011 out_valid  out  1  decoded instruction available.
REQ-012 out_ready  in  1  register-read stage consumes.
REQ-013 RD, RS, RX, RK  out  DIR each  register indices to register bank.
REQ-014 WE  out  1  instruction writes RD at writeback.
REQ-015 op  out  4  opcode.
REQ-016 imm  out  BUS  sign-extended imm16.
REQ-017 pc  out  BUS  captured in_pc.
REQ-018 illegal  out  1  decoded instruction is illegal (treated as no-write).

Function
REQ-019 Field map SHALL be: op=[31:28], RD=[27:24], RS=[23:20], RX=[19:16], RK=[15:12], imm16=[15:0].
REQ-020 Classes SHALL be: op 0-7 ALU (reads RS,RX; writes RD); 8 LOAD (reads RS; writes RD); 9 STORE (reads RS,RD; no write); 10 BRANCH (reads RS,RX; no write); 11 KREAD (reads RK; writes RD); 15 NOP (no reads/writes); 12-14 illegal.
REQ-021 Writing class with RD=15 SHALL set illegal=1, WE=0.
REQ-022 Scoreboard: 16-bit pending vector; bit 15 SHALL never be set.
REQ-023 Hazard SHALL exist when any register read by the offered instruction, or its RD when it writes, has pending=1 and is not retired this cycle (wb_valid && wb_rd==index releases it same cycle).
REQ-024 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-025 On in_valid && in_ready, outputs SHALL load decoded fields next posedge; latency exactly 1 cycle; out_valid=1.
REQ-026 out_valid && !out_ready SHALL hold all outputs stable.
REQ-027 out_valid SHALL drop after handshake when no new accept occurs.
REQ-028 Accept with WE=1 SHALL set pending[RD]; wb_valid SHALL clear pending[wb_rd]; same index set and clear in one cycle: set wins.
REQ-029 flush SHALL clear out_valid next cycle and block acceptance; pending SHALL be unchanged (in-flight writes still retire).
REQ-030 wb_valid for a non-pending register SHALL be ignored.

Reset
REQ-031 rst_n=0 at posedge SHALL clear out_valid, pending, WE, illegal, and zero RD/RS/RX/RK/op/imm/pc; in_ready=0 while rst_n=0.
REQ-032 Reset mid-stall or mid-handshake SHALL discard the held instruction with no pending bit left set.

Structure
REQ-033 Shared package SHALL hold opcode enum, class codes, field bit positions, and PC index constant 15.
REQ-034 One sub-module, decode_scoreboard, SHALL hold pending vector and hazard logic.

Verification
REQ-035 ALU op 1 RD=3 RS=1 RX=2, out_ready=1 -> out_valid next cycle, WE=1, pending[3]=1.
REQ-036 Then ALU reads RS=3 with no wb -> in_ready=0; wb_valid wb_rd=3 -> accepted same cycle, pending[3] cleared then re-set only if new RD=3.
REQ-037 out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no extra accept.
REQ-038 op 8 RD=15 -> illegal=1, WE=0, pending unchanged; op 13 -> illegal=1.
REQ-039 imm16=0x8001 -> imm=0xFFFF8001; flush with out_valid=1 -> out_valid=0 next cycle, pending kept.
REQ-040 rst_n=0 during stall with pending[5]=1 -> all outputs zero, pending=0 after one posedge.
